// File: rtl/crd_drop.sv
// crd_drop: removes outer coordinates whose inner fiber is empty.
// The inner stream passes through unchanged. Each output has its own FIFO.

// Small FIFO; pop is applied before push, so a full FIFO can accept
// a new token in the same cycle it is popped.
module crd_drop_fifo #(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_head,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (i_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;
endmodule

module crd_drop #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          tile_en,
    input  logic          drop_en,
    input  logic [DATA_W:0] crd_in_0,
    input  logic          crd_in_0_valid,
    output logic          crd_in_0_ready,
    input  logic [DATA_W:0] crd_in_1,
    input  logic          crd_in_1_valid,
    output logic          crd_in_1_ready,
    output logic [DATA_W:0] crd_out_0,
    output logic          crd_out_0_valid,
    input  logic          crd_out_0_ready,
    output logic [DATA_W:0] crd_out_1,
    output logic          crd_out_1_valid,
    input  logic          crd_out_1_ready
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [DATA_W:0] TOK_DONE = {1'b1, DATA_W'(16'h0100)};

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_FIBER,
        ST_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [DATA_W:0] r_hold;
    logic [DATA_W:0] w_hold_nx;
    logic          r_has;
    logic          w_has_nx;

    logic          w_act;
    logic          w_push0;
    logic          w_push1;
    logic [DATA_W:0] w_push1_data;
    logic          w_pop0;
    logic          w_pop1;
    logic [DATA_W:0] w_head0;
    logic [DATA_W:0] w_head1;
    logic [CW-1:0] w_cnt0;
    logic [CW-1:0] w_cnt1;
    logic          w_ne0;
    logic          w_ne1;
    logic          w_sp0;
    logic          w_sp1;
    logic          w_rdy0;
    logic          w_rdy1;
    logic          w_in0_data;
    logic          w_in0_done;
    logic          w_in1_data;
    logic          w_in1_done;

    assign w_act      = rst_n & tile_en;
    assign w_in0_data = ~crd_in_0[DATA_W];
    assign w_in0_done = (crd_in_0 == TOK_DONE);
    assign w_in1_data = ~crd_in_1[DATA_W];
    assign w_in1_done = (crd_in_1 == TOK_DONE);

    assign w_ne0  = (w_cnt0 != '0);
    assign w_ne1  = (w_cnt1 != '0);
    assign w_pop0 = w_act & clk_en & w_ne0 & crd_out_0_ready;
    assign w_pop1 = w_act & clk_en & w_ne1 & crd_out_1_ready;
    // Space counts a same-cycle pop so a full FIFO keeps full rate.
    assign w_sp0  = (w_cnt0 < DEPTH_C) | w_pop0;
    assign w_sp1  = (w_cnt1 < DEPTH_C) | w_pop1;

    crd_drop_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push0),
        .i_pop   (w_pop0),
        .i_data  (crd_in_0),
        .o_head  (w_head0),
        .o_count (w_cnt0)
    );

    crd_drop_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push1),
        .i_pop   (w_pop1),
        .i_data  (w_push1_data),
        .o_head  (w_head1),
        .o_count (w_cnt1)
    );

    // State, held coordinate and fiber-has-data flag; frozen when gated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_hold  <= '0;
            r_has   <= 1'b0;
        end else if (clk_en && tile_en) begin
            r_state <= w_state_nx;
            r_hold  <= w_hold_nx;
            r_has   <= w_has_nx;
        end
    end

    // Next state, port readies and FIFO pushes.
    always_comb begin
        w_state_nx   = r_state;
        w_hold_nx    = r_hold;
        w_has_nx     = r_has;
        w_rdy0       = 1'b0;
        w_rdy1       = 1'b0;
        w_push0      = 1'b0;
        w_push1      = 1'b0;
        w_push1_data = crd_in_1;
        case (r_state)
            ST_FETCH: begin
                w_rdy1 = w_act & w_sp1;
                if (w_rdy1 && crd_in_1_valid && clk_en) begin
                    if (w_in1_data) begin
                        w_hold_nx  = crd_in_1;
                        w_has_nx   = 1'b0;
                        w_state_nx = ST_FIBER;
                    end else if (w_in1_done) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_push1 = 1'b1;
                    end
                end
            end
            ST_FIBER: begin
                w_rdy0 = w_act & w_sp0 & ~w_in0_done & (w_in0_data | w_sp1);
                if (w_rdy0 && crd_in_0_valid && clk_en) begin
                    w_push0 = 1'b1;
                    if (w_in0_data) begin
                        w_has_nx = 1'b1;
                    end else begin
                        w_push1      = r_has | ~drop_en;
                        w_push1_data = r_hold;
                        w_state_nx   = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                w_rdy0 = w_act & w_sp0 & w_sp1;
                if (w_rdy0 && crd_in_0_valid && clk_en) begin
                    w_push0 = 1'b1;
                    if (w_in0_done) begin
                        w_push1      = 1'b1;
                        w_push1_data = TOK_DONE;
                        w_state_nx   = ST_FETCH;
                    end
                end
            end
            default: begin
                w_state_nx = ST_FETCH;
            end
        endcase
    end

    assign crd_in_0_ready  = w_rdy0;
    assign crd_in_1_ready  = w_rdy1;
    assign crd_out_0_valid = w_act & w_ne0;
    assign crd_out_1_valid = w_act & w_ne1;
    assign crd_out_0       = rst_n ? w_head0 : '0;
    assign crd_out_1       = rst_n ? w_head1 : '0;
endmodule

// File: tb/tb_crd_drop.sv
// Self-checking bench for crd_drop: directed test-plan streams plus random
// legal streams, checked against a stream-level reference model.
module tb_crd_drop;
    localparam int DW = 16;
    typedef logic [DW:0] tok_t;
    localparam tok_t TOK_D = 17'h1_0100;

    logic clk = 1'b0;
    logic rst_n, clk_en, tile_en, drop_en;
    tok_t crd_in_0, crd_in_1, crd_out_0, crd_out_1;
    logic crd_in_0_valid, crd_in_0_ready, crd_in_1_valid, crd_in_1_ready;
    logic crd_out_0_valid, crd_out_0_ready, crd_out_1_valid, crd_out_1_ready;

    always #5 clk = ~clk;

    crd_drop #(.DATA_W(DW), .FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en          (clk_en),
        .tile_en         (tile_en),
        .drop_en         (drop_en),
        .crd_in_0        (crd_in_0),
        .crd_in_0_valid  (crd_in_0_valid),
        .crd_in_0_ready  (crd_in_0_ready),
        .crd_in_1        (crd_in_1),
        .crd_in_1_valid  (crd_in_1_valid),
        .crd_in_1_ready  (crd_in_1_ready),
        .crd_out_0       (crd_out_0),
        .crd_out_0_valid (crd_out_0_valid),
        .crd_out_0_ready (crd_out_0_ready),
        .crd_out_1       (crd_out_1),
        .crd_out_1_valid (crd_out_1_valid),
        .crd_out_1_ready (crd_out_1_ready)
    );

    int compared   = 0;
    int mismatched = 0;

    tok_t q_in0[$], q_in1[$], e_out0[$], e_out1[$], got0[$], got1[$];
    int   p_valid, p_ready, hold1, gate_at, gate_len, p_tile_off;
    bit   saw_in1_block;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic tok_t td(input int v);
        logic [15:0] c;
        c = v[15:0];
        return {1'b0, c};
    endfunction

    function automatic tok_t ts(input int n);
        logic [7:0] l;
        l = n[7:0];
        return {1'b1, 8'h00, l};
    endfunction

    // Reference: inner passes unchanged; each outer coordinate consumes one
    // inner fiber (data up to its stop) and survives if that fiber had data
    // or dropping is disabled; outer stops and D always survive.
    task automatic build_expected();
        int j;
        bit ne;
        e_out0 = q_in0;
        e_out1.delete();
        j = 0;
        foreach (q_in1[k]) begin
            if (q_in1[k][DW] == 1'b0) begin
                ne = 1'b0;
                while (j < q_in0.size() && q_in0[j][DW] == 1'b0) begin
                    ne = 1'b1;
                    j++;
                end
                j++;
                if (ne || !drop_en) e_out1.push_back(q_in1[k]);
            end else begin
                e_out1.push_back(q_in1[k]);
            end
        end
    endtask

    task automatic set_knobs(input int pv, input int pr, input int h1,
                             input int ga, input int gl, input int pt);
        p_valid = pv; p_ready = pr; hold1 = h1;
        gate_at = ga; gate_len = gl; p_tile_off = pt;
    endtask

    // Drive both input streams, collect both outputs; abort_cyc>0 stops early.
    task automatic run_stream(input string tag, input int abort_cyc);
        int   i0, i1, cyc;
        bit   fin, tmo, f0, f1;
        tok_t s0, s1;
        logic sv0, sv1;
        i0 = 0; i1 = 0; cyc = 0; fin = 0; tmo = 0;
        s0 = '0; s1 = '0; sv0 = 0; sv1 = 0;
        got0.delete(); got1.delete();
        saw_in1_block = 0;
        build_expected();
        while (!fin) begin
            @(negedge clk);
            clk_en  = !(gate_len > 0 && cyc >= gate_at && cyc < gate_at + gate_len);
            tile_en = ($urandom_range(99, 0) >= p_tile_off);
            if (i0 < q_in0.size()) begin
                crd_in_0 = q_in0[i0];
                crd_in_0_valid = ($urandom_range(99, 0) < p_valid);
            end else begin
                crd_in_0 = '0;
                crd_in_0_valid = 1'b0;
            end
            if (i1 < q_in1.size()) begin
                crd_in_1 = q_in1[i1];
                crd_in_1_valid = ($urandom_range(99, 0) < p_valid);
            end else begin
                crd_in_1 = '0;
                crd_in_1_valid = 1'b0;
            end
            crd_out_0_ready = ($urandom_range(99, 0) < p_ready);
            crd_out_1_ready = (cyc < hold1) ? 1'b0 : ($urandom_range(99, 0) < p_ready);
            #1;
            if (!tile_en) begin
                chk($sformatf("%s gated in0_ready", tag), crd_in_0_ready, 0);
                chk($sformatf("%s gated in1_ready", tag), crd_in_1_ready, 0);
                chk($sformatf("%s gated out0_valid", tag), crd_out_0_valid, 0);
                chk($sformatf("%s gated out1_valid", tag), crd_out_1_valid, 0);
            end
            if (!clk_en && cyc == gate_at) begin
                s0 = crd_out_0; s1 = crd_out_1;
                sv0 = crd_out_0_valid; sv1 = crd_out_1_valid;
            end else if (!clk_en) begin
                chk($sformatf("%s hold out0 c%0d", tag, cyc), crd_out_0, s0);
                chk($sformatf("%s hold out1 c%0d", tag, cyc), crd_out_1, s1);
                chk($sformatf("%s hold v0 c%0d", tag, cyc), crd_out_0_valid, sv0);
                chk($sformatf("%s hold v1 c%0d", tag, cyc), crd_out_1_valid, sv1);
            end
            if (cyc < hold1 && crd_in_1_valid && !crd_in_1_ready) saw_in1_block = 1;
            f0 = crd_in_0_valid & crd_in_0_ready & clk_en & tile_en;
            f1 = crd_in_1_valid & crd_in_1_ready & clk_en & tile_en;
            if (crd_out_0_valid && crd_out_0_ready && clk_en && tile_en) got0.push_back(crd_out_0);
            if (crd_out_1_valid && crd_out_1_ready && clk_en && tile_en) got1.push_back(crd_out_1);
            @(posedge clk);
            if (f0) i0++;
            if (f1) i1++;
            cyc++;
            if (abort_cyc > 0) begin
                fin = (cyc >= abort_cyc);
            end else if (i0 == q_in0.size() && i1 == q_in1.size() &&
                         got0.size() >= e_out0.size() && got1.size() >= e_out1.size()) begin
                fin = 1;
            end else if (cyc >= 3000) begin
                fin = 1; tmo = 1;
            end
        end
        if (abort_cyc == 0) begin
            chk($sformatf("%s timeout", tag), tmo, 0);
            chk($sformatf("%s out0 count", tag), got0.size(), e_out0.size());
            chk($sformatf("%s out1 count", tag), got1.size(), e_out1.size());
            for (int k = 0; k < e_out0.size() && k < got0.size(); k++)
                chk($sformatf("%s out0[%0d]", tag, k), got0[k], e_out0[k]);
            for (int k = 0; k < e_out1.size() && k < got1.size(); k++)
                chk($sformatf("%s out1[%0d]", tag, k), got1[k], e_out1[k]);
            @(negedge clk);
            clk_en = 1; tile_en = 1;
            crd_in_0_valid = 0; crd_in_1_valid = 0;
            crd_out_0_ready = 1; crd_out_1_ready = 1;
            #1;
            chk($sformatf("%s no extra out0", tag), crd_out_0_valid, 0);
            chk($sformatf("%s no extra out1", tag), crd_out_1_valid, 0);
        end
    endtask

    task automatic basic_stream();
        q_in1 = '{td(0), td(2), ts(0), TOK_D};
        q_in0 = '{td(5), td(7), ts(0), td(3), ts(1), TOK_D};
    endtask

    task automatic empty_fiber_stream();
        q_in1 = '{td(0), td(1), td(2), ts(0), TOK_D};
        q_in0 = '{td(4), ts(0), ts(0), td(6), ts(1), TOK_D};
    endtask

    task automatic gen_random();
        int nf, k, len;
        q_in0.delete(); q_in1.delete();
        nf = $urandom_range(3, 1);
        for (int f = 0; f < nf; f++) begin
            k = $urandom_range(3, 0);
            for (int c = 0; c < k; c++) begin
                q_in1.push_back(td($urandom_range(1000, 0)));
                len = $urandom_range(3, 0);
                for (int d = 0; d < len; d++) q_in0.push_back(td($urandom_range(65535, 0)));
                q_in0.push_back(ts($urandom_range(2, 0)));
            end
            q_in1.push_back(ts(0));
        end
        q_in1.push_back(TOK_D);
        q_in0.push_back(TOK_D);
    endtask

    initial begin
        rst_n = 0; clk_en = 1; tile_en = 1; drop_en = 1;
        crd_in_0 = td(9); crd_in_0_valid = 1;
        crd_in_1 = td(9); crd_in_1_valid = 1;
        crd_out_0_ready = 1; crd_out_1_ready = 1;
        set_knobs(100, 100, 0, 0, 0, 0);

        // Reset cycle: everything quiet even with inputs offered.
        @(negedge clk); #1;
        chk("rst in0_ready", crd_in_0_ready, 0);
        chk("rst in1_ready", crd_in_1_ready, 0);
        chk("rst out0_valid", crd_out_0_valid, 0);
        chk("rst out1_valid", crd_out_1_valid, 0);
        chk("rst out0 data", crd_out_0, 0);
        chk("rst out1 data", crd_out_1, 0);
        @(negedge clk);
        rst_n = 1; crd_in_0_valid = 0; crd_in_1_valid = 0;
        #1;
        chk("post-rst out0_valid", crd_out_0_valid, 0);
        chk("post-rst out1_valid", crd_out_1_valid, 0);

        // Single outer stop: visible the cycle after acceptance.
        @(negedge clk);
        crd_in_1 = ts(3); crd_in_1_valid = 1; crd_out_1_ready = 0;
        #1;
        chk("lat in1_ready", crd_in_1_ready, 1);
        @(negedge clk);
        crd_in_1_valid = 0;
        #1;
        chk("lat out1_valid", crd_out_1_valid, 1);
        chk("lat out1 data", crd_out_1, ts(3));
        crd_out_1_ready = 1;
        @(negedge clk); #1;
        chk("lat drained", crd_out_1_valid, 0);

        drop_en = 1; set_knobs(100, 100, 0, 0, 0, 0);
        basic_stream();       run_stream("basic", 0);
        empty_fiber_stream(); run_stream("empty", 0);
        q_in1 = '{td(1), ts(0), TOK_D};
        q_in0 = '{ts(1), TOK_D};
        run_stream("allempty", 0);

        set_knobs(100, 100, 10, 0, 0, 0);
        basic_stream(); run_stream("bp", 0);
        chk("bp outer blocked", saw_in1_block, 1);

        drop_en = 0; set_knobs(100, 100, 0, 0, 0, 0);
        empty_fiber_stream(); run_stream("bypass", 0);
        set_knobs(100, 100, 0, 4, 3, 0);
        empty_fiber_stream(); run_stream("bypass-gate", 0);

        // Reset while in a fiber with both FIFOs occupied.
        drop_en = 1; set_knobs(100, 0, 0, 0, 0, 0);
        q_in1 = '{ts(0), td(4), ts(0), TOK_D};
        q_in0 = '{td(8), td(9), ts(0), TOK_D};
        run_stream("prerst", 6);
        @(negedge clk);
        clk_en = 1; tile_en = 1; #1;
        chk("midrst pre v0", crd_out_0_valid, 1);
        chk("midrst pre v1", crd_out_1_valid, 1);
        rst_n = 0; #1;
        chk("midrst v0", crd_out_0_valid, 0);
        chk("midrst v1", crd_out_1_valid, 0);
        chk("midrst rdy0", crd_in_0_ready, 0);
        @(negedge clk);
        rst_n = 1; crd_in_0_valid = 0; crd_in_1_valid = 0; #1;
        chk("midrst after v0", crd_out_0_valid, 0);
        chk("midrst after v1", crd_out_1_valid, 0);
        set_knobs(100, 100, 0, 0, 0, 0);
        basic_stream(); run_stream("replay", 0);

        for (int it = 0; it < 30; it++) begin
            drop_en = $urandom_range(3, 0) != 0;
            set_knobs($urandom_range(100, 50), $urandom_range(100, 30), 0, 0, 0, 10);
            gen_random();
            run_stream($sformatf("rnd%0d", it), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/crd_drop.md
# crd_drop

Sparse-stream coordinate drop unit for the SAM-style primitive tiles. It is the compressing counterpart of the coordinate-hold block: it consumes an outer coordinate stream and its inner (child) coordinate stream, and removes every outer coordinate whose inner fiber is empty. The inner stream passes through unchanged. The block sits downstream of intersect/merge stages, where empty fibers appear.

## Interface
Parameters:
- DATA_W, 16, coordinate payload width; the token is DATA_W+1 bits.
- FIFO_DEPTH, 2, depth of each output FIFO; a power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- clk_en  in  1  when low, all state holds and no transfers occur
- tile_en  in  1  when low, all ready/valid outputs are 0 and state holds
- drop_en  in  1  config; 0 = bypass (forward every outer token)
- crd_in_0  in  17  inner token
- crd_in_0_valid  in  1
- crd_in_0_ready  out  1
- crd_in_1  in  17  outer token
- crd_in_1_valid  in  1
- crd_in_1_ready  out  1
- crd_out_0  out  17  inner token out
- crd_out_0_valid  out  1
- crd_out_0_ready  in  1
- crd_out_1  out  17  filtered outer token out
- crd_out_1_valid  out  1
- crd_out_1_ready  in  1

## Operation
- Token encoding:
  - bit16=0: data coordinate in [15:0].
  - bit16=1, [9:8]=00: stop token S_n, where n=[7:0].
  - 17'h1_0100: done token D.
- Transfer on a port occurs when valid&ready are high, clk_en=1 and tile_en=1.
- Each output is fed by a FIFO of depth FIFO_DEPTH. The output valid signal is FIFO-not-empty, and the output data is the FIFO head.
- FSM states: FETCH, FIBER, DONE.
  - FETCH: the outer port is ready iff the out_1 FIFO has space.
    - Outer data coordinate: latch it into hold_crd, clear has_data, go to FIBER. Nothing is pushed.
    - Outer stop: push it to out_1 and stay in FETCH.
    - Outer D: go to DONE. Nothing is pushed yet.
    - The inner port is not ready in FETCH.
  - FIBER: the inner port is ready iff the out_0 FIFO has space AND (inner token is data OR out_1 FIFO has space).
    - Inner data: push it to out_0 and set has_data.
    - Inner stop: push it to out_0. If has_data=1 or drop_en=0, push hold_crd to out_1 in the same cycle. Go to FETCH.
    - Inner D while in FIBER is a protocol violation: ready stays 0 and the block stalls.
    - The outer port is not ready in FIBER.
  - DONE: the inner port is ready iff both FIFOs have space.
    - Inner stops and data pass through to out_0. These are trailing tokens and do not occur in legal streams.
    - Inner D: push D to out_0 and to out_1 in the same cycle, then go to FETCH.
- Exactly one inner stop token closes each outer data coordinate; its level is irrelevant to the drop decision.
- Outer stop tokens are never dropped, even when every coordinate in their fiber was dropped.

## Timing
- Reset values, applied on the cycle rst_n=0 is sampled:
  - state=FETCH, FIFOs empty, hold_crd=0, has_data=0.
  - All *_valid=0, all *_ready=0 during the reset cycle, crd_out_*=0.
- Reset mid-stream discards all in-flight tokens, with no partial output. The first transfer can occur on the cycle after rst_n is sampled high.
- Latency:
  - An input accepted in cycle t is visible on its output with valid=1 in cycle t+1 when the FIFO was empty.
  - A kept outer coordinate appears in the cycle after its closing inner stop is accepted.
- Throughput: one inner token per cycle inside a fiber. An outer data coordinate costs one extra cycle in FETCH.
- FIFO behaviour:
  - A pop and a push in the same cycle are allowed when the FIFO is full, because pop is evaluated first. A full FIFO therefore sustains full rate.
  - Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.
- Readies are combinational from state, FIFO counts and the input token. Valid outputs do not depend combinationally on the ready inputs.
- clk_en=0 or tile_en=0 freezes the FSM, FIFOs, hold_crd and has_data. Output data stays stable.

## Test plan
- Basic drop:
  - Stimulus: outer 0,2,S0,D; inner 5,7,S0,3,S1,D; all readies 1.
  - Required: out_1 = 0,2,S0,D; out_0 = the inner stream unchanged.
- Empty fiber:
  - Stimulus: outer 0,1,2,S0,D; inner 4,S0,S0,6,S1,D.
  - Required: out_1 = 0,2,S0,D, with coordinate 1 dropped.
- All empty:
  - Stimulus: outer 1,S0,D; inner S1,D.
  - Required: out_1 = S0,D; out_0 = S1,D.
- Backpressure:
  - Stimulus: the basic-drop stream with crd_out_1_ready=0 for 10 cycles.
  - Required: no token is lost or duplicated. crd_in_0_ready falls when an inner stop arrives with the out_1 FIFO full. Final streams match the basic-drop case.
- Bypass and gating:
  - Stimulus: drop_en=0 with the empty-fiber stream.
  - Required: out_1 = 0,1,2,S0,D.
  - Then toggle clk_en=0 for 3 cycles mid-fiber. Required: outputs hold and the streams are unchanged.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 for 1 cycle while in FIBER with both FIFOs holding tokens.
  - Required: all valids are 0 the next cycle. Replaying the basic-drop stream then yields the basic-drop result.
